// File: rtl/neuron_row_sequencer_if.sv
// -----------------------------------------------------------------------------
// neuron_row_sequencer_if
// Bundles the image-level handshake and the row-control outputs of the neuron
// row sequencer.
//   start          : begin one image (driven by the master)
//   stall          : hold row issue; present only with NEURON_SEQ_STALL_EN
//   WeightX_Select : weight row select
//   PixelX_Select  : pixel row select (always equal to WeightX_Select)
//   ENX_Int        : one-hot accumulator row enable
//   ENX            : output-flop enable pulse
//   busy           : image in flight
//   done           : neuron outputs valid (single-cycle pulse)
// Modports: master (image source / bench), slave (sequencer).
// -----------------------------------------------------------------------------
interface neuron_row_sequencer_if #(
   parameter int ROWS  = 28,
   parameter int SEL_W = 5
);
   logic             start;
`ifdef NEURON_SEQ_STALL_EN
   logic             stall;
`endif
   logic [SEL_W-1:0] WeightX_Select;
   logic [SEL_W-1:0] PixelX_Select;
   logic [ROWS-1:0]  ENX_Int;
   logic             ENX;
   logic             busy;
   logic             done;

`ifdef NEURON_SEQ_STALL_EN
   modport master (output start, stall,
                   input  WeightX_Select, PixelX_Select, ENX_Int, ENX, busy, done);
   modport slave  (input  start, stall,
                   output WeightX_Select, PixelX_Select, ENX_Int, ENX, busy, done);
`else
   modport master (output start,
                   input  WeightX_Select, PixelX_Select, ENX_Int, ENX, busy, done);
   modport slave  (input  start,
                   output WeightX_Select, PixelX_Select, ENX_Int, ENX, busy, done);
`endif
endinterface

// File: rtl/neuron_row_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_row_sequencer
// Control stage in front of a layer of neuron datapaths. Per image it steps the
// ROWS weight/pixel row selects, raises the one-hot accumulator row enable
// PIPE_LAT cycles after each row select, strobes the output flop FINAL_LAT
// cycles after the last row enable, then pulses done.
// Ports:
//   clk         : system clock
//   GlobalReset : synchronous active-high reset (aborts any image in flight)
//   bus         : neuron_row_sequencer_if.slave (start, selects, enables,
//                 busy, done, and stall when enabled)
// Optional feature: define NEURON_SEQ_STALL_EN to add the stall input, which
// holds row issue in ISSUE and delays all later enables by one cycle each.
// -----------------------------------------------------------------------------
module neuron_row_sequencer #(
   parameter int ROWS      = 28,
   parameter int SEL_W     = 5,
   parameter int PIPE_LAT  = 6,
   parameter int FINAL_LAT = 5
) (
   input  logic                 clk,
   input  logic                 GlobalReset,
   neuron_row_sequencer_if.slave bus
);
   localparam int CNT_W = (FINAL_LAT > 1) ? $clog2(FINAL_LAT) : 1;
   localparam int DL_W  = SEL_W + 1;   // {valid, row}

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FINAL, DONE} state_t;

   state_t           state_q;
   logic [SEL_W-1:0] row_q;
   logic             iss_vld_q;   // current select is a fresh row, not a stall hold
   logic [CNT_W-1:0] cnt_q;
   logic             enx_q;
   logic             busy_q;
   logic             done_q;

   logic [PIPE_LAT-1:0][DL_W-1:0] dl_q;
   logic [PIPE_LAT:0][DL_W-1:0]   dl_d;
   logic                          push_vld_w;
   logic                          tail_vld_w;
   logic [SEL_W-1:0]              tail_row_w;
   logic                          last_en_w;
   logic                          row_last_w;
   logic                          stall_w;
   logic [ROWS-1:0]               enx_int_w;

`ifdef NEURON_SEQ_STALL_EN
   assign stall_w = bus.stall;
`else
   assign stall_w = 1'b0;
`endif

   assign push_vld_w = (state_q == ISSUE) && iss_vld_q;
   // Entry 0 is the newest; the slice below drops the oldest entry.
   assign dl_d       = {dl_q, {push_vld_w, row_q}};
   assign tail_vld_w = dl_q[PIPE_LAT-1][SEL_W];
   assign tail_row_w = dl_q[PIPE_LAT-1][SEL_W-1:0];
   assign last_en_w  = tail_vld_w && (tail_row_w == SEL_W'(ROWS - 1));
   assign row_last_w = (row_q == SEL_W'(ROWS - 1));

   always_comb begin
      enx_int_w = '0;
      if (tail_vld_w) begin
         enx_int_w[tail_row_w] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         state_q   <= IDLE;
         row_q     <= '0;
         iss_vld_q <= 1'b0;
         cnt_q     <= '0;
         enx_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dl_q      <= '0;
      end else begin
         dl_q <= dl_d[PIPE_LAT-1:0];
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q   <= ISSUE;
                  row_q     <= '0;
                  iss_vld_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            ISSUE: begin
               // Once the last row has been issued there is nothing left to
               // hold, so stall no longer matters and the counter never wraps.
               if (row_last_w && iss_vld_q) begin
                  state_q   <= DRAIN;
                  row_q     <= '0;
                  iss_vld_q <= 1'b0;
               end else if (stall_w) begin
                  iss_vld_q <= 1'b0;
               end else begin
                  row_q     <= row_q + SEL_W'(1);
                  iss_vld_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (last_en_w) begin
                  state_q <= FINAL;
                  cnt_q   <= CNT_W'(FINAL_LAT - 1);
                  // With a one-cycle final latency ENX lands on the first FINAL cycle.
                  enx_q   <= (FINAL_LAT == 1);
               end
            end
            FINAL: begin
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  enx_q   <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  enx_q <= (cnt_q == CNT_W'(1));
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.WeightX_Select = row_q;
   assign bus.PixelX_Select  = row_q;
   assign bus.ENX_Int        = enx_int_w;
   assign bus.ENX            = enx_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
endmodule

// File: tb/tb_neuron_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_row_sequencer
// Drives two sequencers in lockstep: instance 0 with default latencies and
// instance 1 with PIPE_LAT=1, FINAL_LAT=1. Every cycle both are compared with
// an event-time reference model; selected cycles of the directed sequences are
// also compared with hand-written expected vectors.
// -----------------------------------------------------------------------------
module tb_neuron_row_sequencer;
   localparam int ROWS  = 28;
   localparam int SEL_W = 5;

   typedef struct {
      int test;
      int inst;
      int cyc;
      int sel;
      int enrow;    // -1: no enable bit expected
      bit enx;
      bit busy;
      bit done;
   } vec_t;

   logic clk;
   logic GlobalReset;
   int   gc;
   int   tc;
   int   n_cmp;
   int   n_fail;
   vec_t vecs[$];

   // Reference model state: per image, the cycle at which each row is issued.
   bit m_act  [2];
   int m_fill [2];
   int m_iss  [2][ROWS];
   int m_pl   [2];
   int m_fl   [2];

   neuron_row_sequencer_if #(.ROWS(ROWS), .SEL_W(SEL_W)) if0 ();
   neuron_row_sequencer_if #(.ROWS(ROWS), .SEL_W(SEL_W)) if1 ();

   neuron_row_sequencer #(.ROWS(ROWS), .SEL_W(SEL_W), .PIPE_LAT(6), .FINAL_LAT(5)) u0 (
      .clk(clk), .GlobalReset(GlobalReset), .bus(if0));
   neuron_row_sequencer #(.ROWS(ROWS), .SEL_W(SEL_W), .PIPE_LAT(1), .FINAL_LAT(1)) u1 (
      .clk(clk), .GlobalReset(GlobalReset), .bus(if1));

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc=%0d tcyc=%0d: got %0h, expected %0h", nm, i, gc, tc, act, exp);
      end
   endtask

   task automatic get_dut(input int i, output logic [SEL_W-1:0] w, output logic [SEL_W-1:0] p,
                          output logic [ROWS-1:0] en, output logic enx, output logic busy,
                          output logic done);
      if (i == 0) begin
         w = if0.WeightX_Select; p = if0.PixelX_Select; en = if0.ENX_Int;
         enx = if0.ENX; busy = if0.busy; done = if0.done;
      end else begin
         w = if1.WeightX_Select; p = if1.PixelX_Select; en = if1.ENX_Int;
         enx = if1.ENX; busy = if1.busy; done = if1.done;
      end
   endtask

   function automatic void model_exp(input int i, input int c, output int sel, output int enrow,
                                     output bit enx, output bit busy, output bit done);
      int e;
      sel = 0; enrow = -1; enx = 0; busy = 0; done = 0;
      if (!m_act[i]) return;
      busy = 1;
      if (m_fill[i] < ROWS || c == m_iss[i][ROWS-1]) sel = m_fill[i] - 1;
      for (int r = 0; r < m_fill[i]; r++)
         if (m_iss[i][r] + m_pl[i] == c) enrow = r;
      if (m_fill[i] == ROWS) begin
         e    = m_iss[i][ROWS-1] + m_pl[i] + m_fl[i];
         enx  = (c == e);
         done = (c == e + 1);
      end
   endfunction

   function automatic void model_upd(input int i, input int c, input bit st, input bit rs, input bit sl);
      int e;
      if (rs) begin
         m_act[i] = 0;
         return;
      end
      if (!m_act[i]) begin
         if (st) begin
            m_act[i]    = 1;
            m_iss[i][0] = c + 1;
            m_fill[i]   = 1;
         end
         return;
      end
      if (m_fill[i] < ROWS) begin
         if (!sl) begin
            m_iss[i][m_fill[i]] = c + 1;
            m_fill[i]++;
         end
      end else begin
         e = m_iss[i][ROWS-1] + m_pl[i] + m_fl[i];
         if (c >= e + 1) m_act[i] = 0;
      end
   endfunction

   function automatic logic [ROWS-1:0] onehot(input int r);
      logic [ROWS-1:0] v;
      v = '0;
      if (r >= 0) v[r] = 1'b1;
      return v;
   endfunction

   task automatic check_cycle(input int test);
      logic [SEL_W-1:0] w, p;
      logic [ROWS-1:0]  en;
      logic             enx, busy, done;
      int               esel, erow;
      bit               eenx, ebusy, edone;
      for (int i = 0; i < 2; i++) begin
         get_dut(i, w, p, en, enx, busy, done);
         model_exp(i, gc, esel, erow, eenx, ebusy, edone);
         cmp("sel", i, 64'(w), 64'(esel));
         cmp("sel_eq", i, 64'(p), 64'(w));
         cmp("enx_int", i, 64'(en), 64'(onehot(erow)));
         cmp("enx_int_onehot", i, 64'($countones(en) <= 1), 64'(1));
         cmp("enx", i, 64'(enx), 64'(eenx));
         cmp("busy", i, 64'(busy), 64'(ebusy));
         cmp("done", i, 64'(done), 64'(edone));
      end
      for (int k = 0; k < vecs.size(); k++) begin
         if (vecs[k].test == test && vecs[k].cyc == tc) begin
            get_dut(vecs[k].inst, w, p, en, enx, busy, done);
            cmp("vec_sel", vecs[k].inst, 64'(w), 64'(vecs[k].sel));
            cmp("vec_enx_int", vecs[k].inst, 64'(en), 64'(onehot(vecs[k].enrow)));
            cmp("vec_enx", vecs[k].inst, 64'(enx), 64'(vecs[k].enx));
            cmp("vec_busy", vecs[k].inst, 64'(busy), 64'(vecs[k].busy));
            cmp("vec_done", vecs[k].inst, 64'(done), 64'(vecs[k].done));
         end
      end
   endtask

   task automatic step(input bit st, input bit rs, input bit sl, input int test);
      if0.start   = st;
      if1.start   = st;
      GlobalReset = rs;
`ifdef NEURON_SEQ_STALL_EN
      if0.stall = sl;
      if1.stall = sl;
`endif
      #3;
      check_cycle(test);
      for (int i = 0; i < 2; i++) model_upd(i, gc, st, rs, sl);
      @(posedge clk);
      #1;
      gc++;
      tc++;
   endtask

   task automatic reset_gap();
      step(1'b0, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 0);
      tc = 0;
   endtask

   initial begin
      // Nominal run, start at 10.
      vecs.push_back('{1, 0,  0,  0, -1, 0, 0, 0});
      vecs.push_back('{1, 0, 10,  0, -1, 0, 0, 0});
      vecs.push_back('{1, 0, 11,  0, -1, 0, 1, 0});
      vecs.push_back('{1, 0, 12,  1, -1, 0, 1, 0});
      vecs.push_back('{1, 0, 16,  5, -1, 0, 1, 0});
      vecs.push_back('{1, 0, 17,  6,  0, 0, 1, 0});
      vecs.push_back('{1, 0, 38, 27, 21, 0, 1, 0});
      vecs.push_back('{1, 0, 39,  0, 22, 0, 1, 0});
      vecs.push_back('{1, 0, 44,  0, 27, 0, 1, 0});
      vecs.push_back('{1, 0, 45,  0, -1, 0, 1, 0});
      vecs.push_back('{1, 0, 48,  0, -1, 0, 1, 0});
      vecs.push_back('{1, 0, 49,  0, -1, 1, 1, 0});
      vecs.push_back('{1, 0, 50,  0, -1, 0, 1, 1});
      vecs.push_back('{1, 0, 51,  0, -1, 0, 0, 0});
      // start held high 10..60.
      vecs.push_back('{2, 0, 20,  9,  3, 0, 1, 0});
      vecs.push_back('{2, 0, 50,  0, -1, 0, 1, 1});
      vecs.push_back('{2, 0, 51,  0, -1, 0, 0, 0});
      vecs.push_back('{2, 0, 52,  0, -1, 0, 1, 0});
      vecs.push_back('{2, 0, 53,  1, -1, 0, 1, 0});
      vecs.push_back('{2, 1, 41,  0, -1, 0, 1, 1});
      vecs.push_back('{2, 1, 43,  0, -1, 0, 1, 0});
      // Reset at 25, restart at 30.
      vecs.push_back('{3, 0, 26,  0, -1, 0, 0, 0});
      vecs.push_back('{3, 1, 26,  0, -1, 0, 0, 0});
      vecs.push_back('{3, 0, 30,  0, -1, 0, 0, 0});
      vecs.push_back('{3, 0, 36,  5, -1, 0, 1, 0});
      vecs.push_back('{3, 0, 37,  6,  0, 0, 1, 0});
      // Minimum latencies, start at 0.
      vecs.push_back('{4, 1,  1,  0, -1, 0, 1, 0});
      vecs.push_back('{4, 1,  2,  1,  0, 0, 1, 0});
      vecs.push_back('{4, 1, 28, 27, 26, 0, 1, 0});
      vecs.push_back('{4, 1, 29,  0, 27, 0, 1, 0});
      vecs.push_back('{4, 1, 30,  0, -1, 1, 1, 0});
      vecs.push_back('{4, 1, 31,  0, -1, 0, 1, 1});
      vecs.push_back('{4, 1, 32,  0, -1, 0, 0, 0});
      vecs.push_back('{4, 0, 39,  0, -1, 1, 1, 0});
      vecs.push_back('{4, 0, 40,  0, -1, 0, 1, 1});
`ifdef NEURON_SEQ_STALL_EN
      // Stall 15..17 in the nominal run.
      vecs.push_back('{5, 0, 15,  4, -1, 0, 1, 0});
      vecs.push_back('{5, 0, 18,  4,  1, 0, 1, 0});
      vecs.push_back('{5, 0, 19,  5,  2, 0, 1, 0});
      vecs.push_back('{5, 0, 21,  7,  4, 0, 1, 0});
      vecs.push_back('{5, 0, 22,  8, -1, 0, 1, 0});
      vecs.push_back('{5, 0, 25, 11,  5, 0, 1, 0});
      vecs.push_back('{5, 0, 52,  0, -1, 1, 1, 0});
      vecs.push_back('{5, 0, 53,  0, -1, 0, 1, 1});
`endif

      m_pl[0] = 6; m_fl[0] = 5;
      m_pl[1] = 1; m_fl[1] = 1;
      for (int i = 0; i < 2; i++) begin
         m_act[i]  = 0;
         m_fill[i] = 0;
      end
      n_cmp = 0; n_fail = 0; gc = 0; tc = 0;

      clk         = 1'b0;
      GlobalReset = 1'b1;
      if0.start   = 1'b0;
      if1.start   = 1'b0;
`ifdef NEURON_SEQ_STALL_EN
      if0.stall = 1'b0;
      if1.stall = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;

      reset_gap();
      for (int t = 0; t <= 55; t++) step(t == 10, 1'b0, 1'b0, 1);

      reset_gap();
      for (int t = 0; t <= 60; t++) step(t >= 10 && t <= 60, 1'b0, 1'b0, 2);

      reset_gap();
      for (int t = 0; t <= 45; t++) step(t == 10 || t == 30, t == 25, 1'b0, 3);

      reset_gap();
      for (int t = 0; t <= 45; t++) step(t == 0, 1'b0, 1'b0, 4);

`ifdef NEURON_SEQ_STALL_EN
      reset_gap();
      for (int t = 0; t <= 56; t++) step(t == 10, 1'b0, t >= 15 && t <= 17, 5);
`endif

      reset_gap();
      for (int t = 0; t < 2500; t++) begin
         bit st, rs, sl;
         st = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 299) == 0);
`ifdef NEURON_SEQ_STALL_EN
         sl = ($urandom_range(0, 3) == 0);
`else
         sl = 1'b0;
`endif
         step(st, rs, sl, 6);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
